// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    // Width of the Tuse/Tnew timing fields.
    localparam int T_W = 2;

    // Tuse value meaning "this source operand is not read".
    localparam logic [T_W-1:0] TUSE_NONE = 2'd3;

    // Default multiply/divide occupancy in cycles.
    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

    // Multiply/divide unit occupancy state.
    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_t;

endpackage

// File: rtl/mdu_busy_cnt.sv
// Multiply/divide busy tracker: counts down the fixed latency of an accepted
// mult/div and reports occupancy. Only instantiated when PIPE_CTRL_MDU_EN is set.
module mdu_busy_cnt
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic clk,
    input  logic res,
    input  logic accept,
    input  logic is_div,
    output logic busy
);

    mdu_state_t state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;

    // State and counter registers; reset aborts any count in flight.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_reg <= MDU_IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state: an accept (re)loads the latency; BUSY counts down and the
    // step that brings the count to zero returns to IDLE, giving exactly N busy cycles.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (state_reg == MDU_BUSY) begin
            if (cnt_reg <= 4'd1) begin
                cnt_next   = 4'd0;
                state_next = MDU_IDLE;
            end else begin
                cnt_next = cnt_reg - 4'd1;
            end
        end
        if (accept) begin
            cnt_next   = is_div ? 4'(DIV_CYC) : 4'(MULT_CYC);
            state_next = MDU_BUSY;
        end
    end

    assign busy = (state_reg == MDU_BUSY);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller for the five-stage pipeline.
// Optional multiply/divide busy tracking is enabled by defining PIPE_CTRL_MDU_EN.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic           clk,
    input  logic           res,
    input  logic [4:0]     D_rs,
    input  logic [4:0]     D_rt,
    input  logic [T_W-1:0] D_Tuse_rs,
    input  logic [T_W-1:0] D_Tuse_rt,
    input  logic [4:0]     E_A3,
    input  logic [4:0]     M_A3,
    input  logic [T_W-1:0] E_Tnew,
    input  logic [T_W-1:0] M_Tnew,
    input  logic           D_is_md,
    input  logic           E_start,
    input  logic           E_is_div,
    input  logic           mem_stall,
    output logic           F_WE,
    output logic           D_WE,
    output logic           E_WE,
    output logic           M_WE,
    output logic           E_clr,
    output logic           W_clr,
    output logic           md_busy
);

    logic [4:0]     src     [2];
    logic [T_W-1:0] src_use [2];
    logic [1:0]     src_stall;
    logic           md_stall;
    logic           hz;

    assign src[0]     = D_rs;
    assign src[1]     = D_rt;
    assign src_use[0] = D_Tuse_rs;
    assign src_use[1] = D_Tuse_rt;

    // Per-source RAW hazard: a producer in E or M writes this register and
    // its result will not be forwardable by the time D needs it.
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        always_comb begin
            src_stall[gi] = 1'b0;
            if (src[gi] != 5'd0 && src_use[gi] != TUSE_NONE) begin
                if ((E_A3 == src[gi] && E_Tnew > src_use[gi]) ||
                    (M_A3 == src[gi] && M_Tnew > src_use[gi]))
                    src_stall[gi] = 1'b1;
            end
        end
    end

    assign hz = src_stall[0] | src_stall[1] | md_stall;

    // Stage enables and clears: memory wait freezes everything and bubbles W;
    // a hazard holds F/D and injects a bubble into E.
    always_comb begin
        F_WE  = 1'b1;
        D_WE  = 1'b1;
        E_WE  = 1'b1;
        M_WE  = 1'b1;
        E_clr = 1'b0;
        W_clr = 1'b0;
        if (mem_stall) begin
            F_WE  = 1'b0;
            D_WE  = 1'b0;
            E_WE  = 1'b0;
            M_WE  = 1'b0;
            W_clr = 1'b1;
        end else if (hz) begin
            F_WE  = 1'b0;
            D_WE  = 1'b0;
            E_clr = 1'b1;
        end
    end

`ifdef PIPE_CTRL_MDU_EN
    logic md_accept;

    // A mult/div start is taken only when it actually leaves E.
    assign md_accept = E_start & M_WE;

    mdu_busy_cnt #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_mdu (
        .clk    (clk),
        .res    (res),
        .accept (md_accept),
        .is_div (E_is_div),
        .busy   (md_busy)
    );

    // The E_start term covers the accept cycle before md_busy rises.
    assign md_stall = D_is_md & (md_busy | E_start);
`else
    // Without the tracker the MDU inputs, clock and reset are not needed.
    localparam int unused_cyc = MULT_CYC + DIV_CYC;
    wire unused_md = &{1'b0, D_is_md, E_start, E_is_div, clk, res, 32'(unused_cyc)};

    assign md_busy  = 1'b0;
    assign md_stall = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios followed by
// randomized cycles, all checked against a behavioural model.
module tb_pipe_stall_ctrl;

`ifdef PIPE_CTRL_MDU_EN
    localparam bit MDU_EN = 1'b1;
`else
    localparam bit MDU_EN = 1'b0;
`endif
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic       clk = 1'b0;
    logic       res;
    logic [4:0] D_rs, D_rt, E_A3, M_A3;
    logic [1:0] D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
    logic       D_is_md, E_start, E_is_div, mem_stall;
    logic       F_WE, D_WE, E_WE, M_WE, E_clr, W_clr, md_busy;

    int n_cmp = 0;
    int n_err = 0;
    int busy_left = 0;     // model: remaining MDU busy cycles
    logic last_busy;
    int busy_cnt;

    pipe_stall_ctrl #(.MULT_CYC(MULT_N), .DIV_CYC(DIV_N)) dut (
        .clk(clk), .res(res),
        .D_rs(D_rs), .D_rt(D_rt), .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
        .E_A3(E_A3), .M_A3(M_A3), .E_Tnew(E_Tnew), .M_Tnew(M_Tnew),
        .D_is_md(D_is_md), .E_start(E_start), .E_is_div(E_is_div),
        .mem_stall(mem_stall),
        .F_WE(F_WE), .D_WE(D_WE), .E_WE(E_WE), .M_WE(M_WE),
        .E_clr(E_clr), .W_clr(W_clr), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    // Operand needs waiting if some in-flight producer writes it and delivers late.
    function automatic bit operand_waits(input logic [4:0] r, input logic [1:0] tuse);
        bit w = 0;
        if (r == 0) return 0;
        if (E_A3 == r && int'(E_Tnew) > int'(tuse)) w = 1;
        if (M_A3 == r && int'(M_Tnew) > int'(tuse)) w = 1;
        return w;
    endfunction

    // Expected {F_WE,D_WE,E_WE,M_WE,E_clr,W_clr,md_busy}.
    function automatic logic [6:0] model_out();
        bit busy = MDU_EN && (busy_left > 0);
        bit hazard = operand_waits(D_rs, D_Tuse_rs) || operand_waits(D_rt, D_Tuse_rt) ||
                     (MDU_EN && D_is_md && (busy || E_start));
        if (mem_stall) return {4'b0000, 1'b0, 1'b1, busy};
        if (hazard)    return {4'b0011, 1'b1, 1'b0, busy};
        return {4'b1111, 1'b0, 1'b0, busy};
    endfunction

    function automatic logic [6:0] obs_out();
        return {F_WE, D_WE, E_WE, M_WE, E_clr, W_clr, md_busy};
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One transaction: check outputs mid-cycle, then advance the model at the edge.
    task automatic do_cycle(input string tag);
        logic [6:0] exp;
        logic [6:0] obs;
        #1;
        if (!res) busy_left = 0;
        exp = model_out();
        obs = obs_out();
        last_busy = md_busy;
        check(tag, obs, exp);
        $display("%-10s rs=%0d rt=%0d eA3=%0d mA3=%0d ms=%0b md=%0b st=%0b dv=%0b -> %b",
                 tag, D_rs, D_rt, E_A3, M_A3, mem_stall, D_is_md, E_start, E_is_div, obs);
        @(posedge clk);
        if (res) begin
            if (MDU_EN && E_start && !mem_stall) busy_left = E_is_div ? DIV_N : MULT_N;
            else if (busy_left > 0) busy_left--;
        end
        @(negedge clk);
    endtask

    task automatic set_idle();
        D_rs = 0; D_rt = 0; D_Tuse_rs = 2'd3; D_Tuse_rt = 2'd3;
        E_A3 = 0; M_A3 = 0; E_Tnew = 0; M_Tnew = 0;
        D_is_md = 0; E_start = 0; E_is_div = 0; mem_stall = 0;
    endtask

    initial begin
        set_idle();
        res = 1'b0;
        @(negedge clk);
        do_cycle("reset");
        check("reset_const", obs_out(), 7'b1111_00_0);
        res = 1'b1;

        // Load-use hazard from E, then the same with register 0.
        D_rs = 5; D_Tuse_rs = 0; E_A3 = 5; E_Tnew = 2;
        #1 check("load_use", obs_out(), 7'b0011_10_0);
        do_cycle("load_use");
        D_rs = 0; E_A3 = 0;
        #1 check("reg0", obs_out(), 7'b1111_00_0);
        do_cycle("reg0");

        // Forwardable from M, then not yet forwardable.
        set_idle();
        M_A3 = 7; M_Tnew = 0; D_rt = 7; D_Tuse_rt = 0;
        #1 check("fwd_ok", obs_out(), 7'b1111_00_0);
        do_cycle("fwd_ok");
        M_Tnew = 1;
        #1 check("fwd_late", obs_out(), 7'b0011_10_0);
        do_cycle("fwd_late");

        // Hazard together with memory wait: memory wait wins, no bubble in E.
        mem_stall = 1;
        #1 check("priority", obs_out(), 7'b0000_01_0);
        do_cycle("priority");

        // Multiply: one-cycle start, D holds an MDU op throughout.
        set_idle();
        E_start = 1; E_is_div = 0; D_is_md = 1;
        do_cycle("mult_acc");
        E_start = 0;
        busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            do_cycle("mult_run");
            if (last_busy) busy_cnt++;
        end
        check("mult_len", 7'(busy_cnt), MDU_EN ? 7'(MULT_N) : 7'd0);

        // Divide held by memory wait for 3 cycles, accepted on release.
        set_idle();
        E_start = 1; E_is_div = 1; mem_stall = 1;
        for (int i = 0; i < 3; i++) do_cycle("div_hold");
        mem_stall = 0;
        #1 check("div_nobusy", {6'b0, md_busy}, 7'd0);
        do_cycle("div_acc");
        E_start = 0;
        busy_cnt = 0;
        for (int i = 0; i < 13; i++) begin
            do_cycle("div_run");
            if (last_busy) busy_cnt++;
        end
        check("div_len", 7'(busy_cnt), MDU_EN ? 7'(DIV_N) : 7'd0);

        // Reset in the middle of a divide (count at 6).
        E_start = 1; E_is_div = 1;
        do_cycle("div2_acc");
        E_start = 0;
        for (int i = 0; i < 4; i++) do_cycle("div2_run");
        res = 1'b0;
        #1 check("rst_busy", {6'b0, md_busy}, 7'd0);
        do_cycle("rst_mid");
        res = 1'b1;
        D_is_md = 1;
        #1 check("post_rst", obs_out(), 7'b1111_00_0);
        do_cycle("post_rst");

        // Randomized traffic with small register numbers to provoke matches.
        for (int i = 0; i < 300; i++) begin
            D_rs      = 5'($urandom_range(0, 3));
            D_rt      = 5'($urandom_range(0, 3));
            D_Tuse_rs = 2'($urandom_range(0, 3));
            D_Tuse_rt = 2'($urandom_range(0, 3));
            E_A3      = 5'($urandom_range(0, 3));
            M_A3      = 5'($urandom_range(0, 3));
            E_Tnew    = 2'($urandom_range(0, 2));
            M_Tnew    = 2'($urandom_range(0, 2));
            D_is_md   = ($urandom_range(0, 2) == 0);
            E_start   = ($urandom_range(0, 5) == 0);
            E_is_div  = $urandom_range(0, 1) != 0;
            mem_stall = ($urandom_range(0, 3) == 0);
            res       = ($urandom_range(0, 60) != 0);
            do_cycle("random");
            res = 1'b1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
